pcie_s10_tx_credit_model: RTL and testbench
===========================================

Name: pcie_s10_tx_credit_model

Overview:
- Device-side counterpart of the H-tile TX AVST interface that the application core drives. It sinks the TX TLP stream and decodes each TLP header.
- It maintains the advertised credit pools tx_*_cdts and generates the tx_hdr_cdts_consumed, tx_data_cdts_consumed, tx_cdts_type and tx_cdts_data_value pulse trains that the hard IP would produce.
- It is used for loopback builds and as the credit source in simulation of the S10 example core.

Parameters:
- SEG_COUNT, 1, segment count; only 1 supported.
- SEG_DATA_WIDTH, 256, TX data width in bits.
- INIT_PH / INIT_NPH / INIT_CPLH, 64 / 64 / 0, initial header credits (8-bit). 0 on CPLH models infinite-advertised, but it is still tracked as a count.
- INIT_PD / INIT_NPD / INIT_CPLD, 512 / 64 / 0, initial data credits (12-bit).
- REPORT_FIFO_DEPTH, 4, pending consumption-report entries (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- tx_st_data  in  SEG_COUNT*SEG_DATA_WIDTH  TLP data; header DW0 in [31:0]
- tx_st_sop  in  SEG_COUNT  start of packet
- tx_st_eop  in  SEG_COUNT  end of packet
- tx_st_valid  in  SEG_COUNT  beat valid
- tx_st_ready  out  1  sink ready
- tx_st_err  in  SEG_COUNT  poison/nullify; ignored for credit accounting
- tx_ph_cdts / tx_nph_cdts / tx_cplh_cdts  out  8  available header credits
- tx_pd_cdts / tx_npd_cdts / tx_cpld_cdts  out  12  available data credits
- tx_hdr_cdts_consumed  out  SEG_COUNT  one pulse per TLP
- tx_data_cdts_consumed  out  SEG_COUNT  one pulse per 1 or 2 data credits
- tx_cdts_type  out  SEG_COUNT*2  00 posted, 01 non-posted, 10 completion
- tx_cdts_data_value  out  SEG_COUNT  0 = 1 credit, 1 = 2 credits
- ret_valid  in  1  credit return strobe
- ret_type  in  2  pool of the return, encoded as tx_cdts_type
- ret_hdr  in  8  header credits returned
- ret_data  in  12  data credits returned
- fc_violation  out  1  sticky: consumption exceeded an available pool
- sop_error  out  1  sticky: sop while inside a packet, or beat outside a packet
- tlp_count  out  32  accepted TLPs; wraps

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: tx_*_cdts = INIT_*; all pulses, type, data_value, sticky flags and tlp_count = 0; tx_st_ready = 1; FIFO empty; FSM IDLE.
- Asserting rst_n mid-packet or mid-pulse-train clears everything immediately; the packet in flight is not reported.

Stream acceptance:
- A beat is accepted when tx_st_valid & tx_st_ready; ready latency is 0.
- tx_st_ready = ~fifo_full, registered.

Header decode (on each accepted sop beat):
- Fields: fmt = DW0[31:29], type = DW0[28:24], len = DW0[9:0]; len 0 means 1024 DW.
- Class posted: MWr (type 00000) or Msg (type 10xxx).
- Class completion: type 01010 or 01011.
- Class non-posted: everything else (MRd, IO, Cfg, atomics).
- has_data = fmt[1].
- dcred = has_data ? ceil(len/4) : 0, so 1..256.
- Push {class, dcred}; tlp_count++.
- An eop beat closes the packet. A single-beat TLP has sop and eop together.

Report FSM (IDLE, HDR, DATA):
- IDLE → HDR when the FIFO is non-empty; pop the entry.
- HDR, one cycle:
  - hdr pulse = 1, type = class.
  - If dcred > 0, data pulse = 1 in the same cycle, value = (rem >= 2), rem -= value ? 2 : 1.
  - Go to DATA if rem > 0, else IDLE.
- DATA: one data pulse per cycle, same chunking rule; → IDLE when rem reaches 0.
- Latency: with the FIFO empty and FSM IDLE, the hdr pulse is driven in cycle N+2, where N is the sop acceptance cycle. FIFO push and pop may occur in the same cycle.

Pool arithmetic:
- Per pool each cycle: next = avail + returned − consumed, computed wide.
- Consumption takes effect on the edge ending the pulse cycle; a simultaneous return and consumption nets out.
- Result > max (255 / 4095) saturates at max.
- Result < 0 clamps to 0 and sets fc_violation.

Test Plan:
1. Release rst_n → tx_ph_cdts=64, tx_pd_cdts=512, tx_nph_cdts=64, tx_st_ready=1, all pulses 0, tlp_count=0.
2. MWr, DW0=0x6000_0010 (len 16), 2 beats → cycle N+2: hdr=1, type=00, data=1, value=1; cycle N+3: data=1, value=1. Then tx_ph_cdts=63, tx_pd_cdts=508, tlp_count=1.
3. MRd len 32, DW0=0x2000_0020 → single hdr pulse with type=01 and no data pulse; tx_nph_cdts 64→63, tx_npd_cdts unchanged. MWr len 5 → one data pulse, value=1; len 1 → one pulse, value=0.
4. CplD len 0 (DW0=0x4A00_0000) then 5 back-to-back single-beat sop TLPs:
   - CplD produces 128 data pulses, all value=1.
   - tx_st_ready drops once 4 entries are pending and returns high after the FIFO pops.
5. ret_valid with ret_type=00, ret_hdr=1 in the same cycle as a posted hdr pulse → tx_ph_cdts unchanged. At tx_ph_cdts=255, return 3 → stays 255.
6. Posted TLP while tx_ph_cdts=0 → fc_violation=1 (sticky), tx_ph_cdts stays 0. Pull rst_n low mid pulse train → pulses drop to 0 asynchronously; pools back to INIT values; sticky flags cleared.

Source files
------------

// File: rtl/pcie_s10_tx_credit_model_if.sv
// TX AVST stream bundle between the application core (master) and the
// credit model that sinks it (slave).
interface pcie_s10_tx_credit_model_if #(
  parameter int SEG_COUNT      = 1,
  parameter int SEG_DATA_WIDTH = 256
);
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] tx_st_data;
  logic [SEG_COUNT-1:0]                tx_st_sop;
  logic [SEG_COUNT-1:0]                tx_st_eop;
  logic [SEG_COUNT-1:0]                tx_st_valid;
  logic [SEG_COUNT-1:0]                tx_st_err;
  logic                                tx_st_ready;

  modport master (
    output tx_st_data, tx_st_sop, tx_st_eop, tx_st_valid, tx_st_err,
    input  tx_st_ready
  );

  modport slave (
    input  tx_st_data, tx_st_sop, tx_st_eop, tx_st_valid, tx_st_err,
    output tx_st_ready
  );
endinterface

// File: rtl/pcie_s10_tx_credit_model.sv
// Device-side model of the S10 H-tile TX credit interface: sinks the TX TLP
// stream, decodes each header into {class, data credits}, queues it, and
// replays it as the hdr/data consumption pulse trains the hard IP produces
// while tracking the six advertised credit pools.
module pcie_s10_tx_credit_model #(
  parameter int          SEG_COUNT         = 1,   // only 1 is supported
  parameter int          SEG_DATA_WIDTH    = 256,
  parameter logic [7:0]  INIT_PH           = 8'd64,
  parameter logic [7:0]  INIT_NPH          = 8'd64,
  parameter logic [7:0]  INIT_CPLH         = 8'd0,
  parameter logic [11:0] INIT_PD           = 12'd512,
  parameter logic [11:0] INIT_NPD          = 12'd64,
  parameter logic [11:0] INIT_CPLD         = 12'd0,
  parameter int          REPORT_FIFO_DEPTH = 4    // power of 2, >= 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pcie_s10_tx_credit_model_if.slave tx_if,
  output logic [7:0]             tx_ph_cdts,
  output logic [7:0]             tx_nph_cdts,
  output logic [7:0]             tx_cplh_cdts,
  output logic [11:0]            tx_pd_cdts,
  output logic [11:0]            tx_npd_cdts,
  output logic [11:0]            tx_cpld_cdts,
  output logic [SEG_COUNT-1:0]   tx_hdr_cdts_consumed,
  output logic [SEG_COUNT-1:0]   tx_data_cdts_consumed,
  output logic [SEG_COUNT*2-1:0] tx_cdts_type,
  output logic [SEG_COUNT-1:0]   tx_cdts_data_value,
  input  logic                   ret_valid,
  input  logic [1:0]             ret_type,
  input  logic [7:0]             ret_hdr,
  input  logic [11:0]            ret_data,
  output logic                   fc_violation,
  output logic                   sop_error,
  output logic [31:0]            tlp_count
);

  localparam int AW = $clog2(REPORT_FIFO_DEPTH);

  localparam logic [1:0] CLS_P   = 2'b00;
  localparam logic [1:0] CLS_NP  = 2'b01;
  localparam logic [1:0] CLS_CPL = 2'b10;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  // ---------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------
  logic        ready_reg;
  logic        beat_acc;
  logic        has_data;
  logic [4:0]  tlp_type;
  logic [9:0]  tlp_len;
  logic [10:0] len_dw;
  logic [10:0] len_round;
  logic [8:0]  dcred;
  logic [1:0]  cls;

  assign beat_acc  = tx_if.tx_st_valid[0] & ready_reg;
  assign has_data  = tx_if.tx_st_data[30];
  assign tlp_type  = tx_if.tx_st_data[28:24];
  assign tlp_len   = tx_if.tx_st_data[9:0];
  assign len_dw    = (tlp_len == 10'd0) ? 11'd1024 : {1'b0, tlp_len};
  assign len_round = len_dw + 11'd3;
  assign dcred     = has_data ? len_round[10:2] : 9'd0;

  // MRd shares type 00000 with MWr, so posted needs the data bit as well.
  always_comb begin
    cls = CLS_NP;
    if ((tlp_type == 5'b00000 && has_data) || tlp_type[4:3] == 2'b10)
      cls = CLS_P;
    else if (tlp_type[4:1] == 4'b0101)
      cls = CLS_CPL;
  end

  // Bits of the stream that carry no credit information.
  logic unused_bits;
  assign unused_bits = ^{tx_if.tx_st_data[SEG_COUNT*SEG_DATA_WIDTH-1:32],
                         tx_if.tx_st_data[31], tx_if.tx_st_data[29],
                         tx_if.tx_st_data[23:10], tx_if.tx_st_err};

  // ---------------------------------------------------------------------
  // Report FIFO: {class, dcred}
  // ---------------------------------------------------------------------
  logic [10:0] fifo_mem [REPORT_FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] fifo_count, fifo_count_next;
  logic        fifo_empty;
  logic        push, pop;
  logic [10:0] head_entry;
  logic [1:0]  head_cls;
  logic [8:0]  head_dcred;
  state_t      state_reg;

  assign push            = beat_acc & tx_if.tx_st_sop[0];
  assign pop             = (state_reg == IDLE) & ~fifo_empty;
  assign fifo_count      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty      = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  // Head is read combinationally so a pop in IDLE can launch the hdr pulse
  // on the very next edge (sop cycle N -> pulse cycle N+2).
  assign head_entry      = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign head_cls        = head_entry[10:9];
  assign head_dcred      = head_entry[8:0];

  // Storage array; holds no state that reset must clear.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {cls, dcred};
  end

  // Stream bookkeeping: pointers, ready, packet framing, TLP counter.
  logic in_pkt_reg, sop_error_reg;
  logic [31:0] tlp_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ready_reg     <= 1'b1;
      in_pkt_reg    <= 1'b0;
      sop_error_reg <= 1'b0;
      tlp_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg    <= wr_ptr_reg + 1'b1;
        tlp_count_reg <= tlp_count_reg + 32'd1;
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Ready reflects the post-edge occupancy, so a full FIFO is never written.
      ready_reg <= (fifo_count_next != (AW+1)'(REPORT_FIFO_DEPTH));
      if (beat_acc) begin
        if (tx_if.tx_st_sop[0] ? in_pkt_reg : ~in_pkt_reg)
          sop_error_reg <= 1'b1;
        in_pkt_reg <= ~tx_if.tx_st_eop[0];
      end
    end
  end

  assign tx_if.tx_st_ready = ready_reg;

  // ---------------------------------------------------------------------
  // Report FSM
  // ---------------------------------------------------------------------
  logic       hdr_pulse_reg, data_pulse_reg, value_reg;
  logic [1:0] type_reg;
  logic [8:0] rem_reg;
  logic [8:0] step_src, step_left;
  logic       step_two;

  // One chunking rule for both the first pulse (from the FIFO head) and the rest.
  assign step_src  = (state_reg == IDLE) ? head_dcred : rem_reg;
  assign step_two  = (step_src >= 9'd2);
  assign step_left = step_src - (step_two ? 9'd2 : 9'd1);

  // Pulse generator with registered outputs; each state is the pulse cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      hdr_pulse_reg  <= 1'b0;
      data_pulse_reg <= 1'b0;
      value_reg      <= 1'b0;
      type_reg       <= 2'b00;
      rem_reg        <= '0;
    end else begin
      hdr_pulse_reg  <= 1'b0;
      data_pulse_reg <= 1'b0;
      value_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            state_reg     <= HDR;
            hdr_pulse_reg <= 1'b1;
            type_reg      <= head_cls;
            rem_reg       <= '0;
            if (head_dcred != 9'd0) begin
              data_pulse_reg <= 1'b1;
              value_reg      <= step_two;
              rem_reg        <= step_left;
            end
          end
        end
        HDR, DATA: begin
          if (rem_reg != 9'd0) begin
            state_reg      <= DATA;
            data_pulse_reg <= 1'b1;
            value_reg      <= step_two;
            rem_reg        <= step_left;
          end else begin
            state_reg <= IDLE;
            type_reg  <= 2'b00;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_hdr_cdts_consumed  = hdr_pulse_reg;
  assign tx_data_cdts_consumed = data_pulse_reg;
  assign tx_cdts_type          = type_reg;
  assign tx_cdts_data_value    = value_reg;

  // ---------------------------------------------------------------------
  // Credit pools: 0 = posted, 1 = non-posted, 2 = completion
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pool
      localparam logic [1:0]  POOL  = 2'(gi);
      localparam logic [7:0]  HINIT = (gi == 0) ? INIT_PH : (gi == 1) ? INIT_NPH : INIT_CPLH;
      localparam logic [11:0] DINIT = (gi == 0) ? INIT_PD : (gi == 1) ? INIT_NPD : INIT_CPLD;

      logic [7:0]  hdr_avail_reg;
      logic [11:0] data_avail_reg;
      logic        ret_hit, use_hit;
      logic        h_use;
      logic [1:0]  d_use;
      logic [8:0]  h_add, h_res;
      logic [12:0] d_add, d_res;
      logic        h_under, d_under;
      logic        viol;

      assign ret_hit = ret_valid & (ret_type == POOL);
      assign use_hit = (type_reg == POOL);
      assign h_use   = hdr_pulse_reg & use_hit;
      assign d_use   = (data_pulse_reg & use_hit) ? (value_reg ? 2'd2 : 2'd1) : 2'd0;
      assign h_add   = {1'b0, hdr_avail_reg} + (ret_hit ? {1'b0, ret_hdr} : 9'd0);
      assign d_add   = {1'b0, data_avail_reg} + (ret_hit ? {1'b0, ret_data} : 13'd0);
      assign h_under = (h_add < {8'd0, h_use});
      assign d_under = (d_add < {11'd0, d_use});
      assign h_res   = h_add - {8'd0, h_use};
      assign d_res   = d_add - {11'd0, d_use};
      // A pool advertised as 0 means infinite: it still clamps, but never flags.
      assign viol    = (h_under & (HINIT != 8'd0)) | (d_under & (DINIT != 12'd0));

      // Net return and consumption, saturating high and clamping at zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hdr_avail_reg  <= HINIT;
          data_avail_reg <= DINIT;
        end else begin
          hdr_avail_reg  <= h_under ? 8'd0 : (h_res[8] ? 8'hFF : h_res[7:0]);
          data_avail_reg <= d_under ? 12'd0 : (d_res[12] ? 12'hFFF : d_res[11:0]);
        end
      end
    end
  endgenerate

  assign tx_ph_cdts   = g_pool[0].hdr_avail_reg;
  assign tx_nph_cdts  = g_pool[1].hdr_avail_reg;
  assign tx_cplh_cdts = g_pool[2].hdr_avail_reg;
  assign tx_pd_cdts   = g_pool[0].data_avail_reg;
  assign tx_npd_cdts  = g_pool[1].data_avail_reg;
  assign tx_cpld_cdts = g_pool[2].data_avail_reg;

  // Sticky flow-control violation flag.
  logic fc_violation_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fc_violation_reg <= 1'b0;
    else if (g_pool[0].viol | g_pool[1].viol | g_pool[2].viol)
      fc_violation_reg <= 1'b1;
  end

  assign fc_violation = fc_violation_reg;
  assign sop_error    = sop_error_reg;
  assign tlp_count    = tlp_count_reg;

endmodule

// File: tb/tb_pcie_s10_tx_credit_model.sv
// Directed bench for pcie_s10_tx_credit_model: drives TLP headers, times the
// consumption pulse trains, and checks pool arithmetic, backpressure, sticky
// flags and asynchronous reset.
module tb_pcie_s10_tx_credit_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ret_valid = 1'b0;
  logic [1:0]  ret_type = 2'b00;
  logic [7:0]  ret_hdr = 8'd0;
  logic [11:0] ret_data = 12'd0;
  logic [7:0]  tx_ph_cdts, tx_nph_cdts, tx_cplh_cdts;
  logic [11:0] tx_pd_cdts, tx_npd_cdts, tx_cpld_cdts;
  logic        hdr_p, data_p, data_v;
  logic [1:0]  cdts_type;
  logic        fc_violation, sop_error;
  logic [31:0] tlp_count;

  int checks = 0;
  int errors = 0;

  // Running pulse totals, used to count long trains without cycle alignment.
  int         tot_hdr = 0;
  int         tot_dp = 0;
  int         tot_v1 = 0;
  logic [1:0] last_typ = 2'b00;
  int h0, d0, v0;

  pcie_s10_tx_credit_model_if #(.SEG_COUNT(1), .SEG_DATA_WIDTH(256)) st ();

  pcie_s10_tx_credit_model dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .tx_if                 (st),
    .tx_ph_cdts            (tx_ph_cdts),
    .tx_nph_cdts           (tx_nph_cdts),
    .tx_cplh_cdts          (tx_cplh_cdts),
    .tx_pd_cdts            (tx_pd_cdts),
    .tx_npd_cdts           (tx_npd_cdts),
    .tx_cpld_cdts          (tx_cpld_cdts),
    .tx_hdr_cdts_consumed  (hdr_p),
    .tx_data_cdts_consumed (data_p),
    .tx_cdts_type          (cdts_type),
    .tx_cdts_data_value    (data_v),
    .ret_valid             (ret_valid),
    .ret_type              (ret_type),
    .ret_hdr               (ret_hdr),
    .ret_data              (ret_data),
    .fc_violation          (fc_violation),
    .sop_error             (sop_error),
    .tlp_count             (tlp_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_p) begin
        tot_hdr  = tot_hdr + 1;
        last_typ = cdts_type;
      end
      if (data_p) begin
        tot_dp = tot_dp + 1;
        if (data_v) tot_v1 = tot_v1 + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One beat, presented at a falling edge; waits (bounded) for ready.
  task automatic send(input logic [31:0] dw0, input logic s, input logic e);
    int n;
    n = 0;
    st.tx_st_data  = {224'd0, dw0};
    st.tx_st_sop   = s;
    st.tx_st_eop   = e;
    st.tx_st_valid = 1'b1;
    while (st.tx_st_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("ready_wait", {31'd0, st.tx_st_ready}, 32'd1);
    @(negedge clk);
    st.tx_st_valid = 1'b0;
    st.tx_st_sop   = 1'b0;
    st.tx_st_eop   = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    h0 = tot_hdr;
    d0 = tot_dp;
    v0 = tot_v1;
  endtask

  task automatic ret_pulse(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    @(negedge clk);
    ret_valid = 1'b1;
    ret_type  = t;
    ret_hdr   = h;
    ret_data  = d;
    @(negedge clk);
    ret_valid = 1'b0;
    ret_hdr   = 8'd0;
    ret_data  = 12'd0;
    @(negedge clk);
  endtask

  initial begin
    st.tx_st_data  = '0;
    st.tx_st_sop   = 1'b0;
    st.tx_st_eop   = 1'b0;
    st.tx_st_valid = 1'b0;
    st.tx_st_err   = 1'b0;

    // 1. reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ph", 32'(tx_ph_cdts), 32'd64);
    chk("rst_nph", 32'(tx_nph_cdts), 32'd64);
    chk("rst_pd", 32'(tx_pd_cdts), 32'd512);
    chk("rst_npd", 32'(tx_npd_cdts), 32'd64);
    chk("rst_cplh", 32'(tx_cplh_cdts), 32'd0);
    chk("rst_ready", 32'(st.tx_st_ready), 32'd1);
    chk("rst_pulses", {29'd0, hdr_p, data_p, data_v}, 32'd0);
    chk("rst_tlp", tlp_count, 32'd0);

    // 2. two-beat MWr len 16: pulses at N+2 and N+3
    send(32'h6000_0010, 1'b1, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b1);
    chk("mwr_n2_hdr", 32'(hdr_p), 32'd1);
    chk("mwr_n2_type", 32'(cdts_type), 32'd0);
    chk("mwr_n2_data", {30'd0, data_p, data_v}, 32'd3);
    @(negedge clk);
    chk("mwr_n3_hdr", 32'(hdr_p), 32'd0);
    chk("mwr_n3_data", {30'd0, data_p, data_v}, 32'd3);
    @(negedge clk);
    chk("mwr_n4_data", 32'(data_p), 32'd0);
    chk("mwr_ph", 32'(tx_ph_cdts), 32'd63);
    chk("mwr_pd", 32'(tx_pd_cdts), 32'd508);
    chk("mwr_tlp", tlp_count, 32'd1);

    // 3. MRd (no data), MWr len 5, MWr len 1
    drain(2); snap();
    send(32'h2000_0020, 1'b1, 1'b1);
    drain(6);
    chk("mrd_hdrs", 32'(tot_hdr - h0), 32'd1);
    chk("mrd_type", 32'(last_typ), 32'd1);
    chk("mrd_dpulses", 32'(tot_dp - d0), 32'd0);
    chk("mrd_nph", 32'(tx_nph_cdts), 32'd63);
    chk("mrd_npd", 32'(tx_npd_cdts), 32'd64);
    snap();
    send(32'h6000_0005, 1'b1, 1'b1);
    drain(6);
    chk("len5_dpulses", 32'(tot_dp - d0), 32'd1);
    chk("len5_val1", 32'(tot_v1 - v0), 32'd1);
    snap();
    send(32'h6000_0001, 1'b1, 1'b1);
    drain(6);
    chk("len1_dpulses", 32'(tot_dp - d0), 32'd1);
    chk("len1_val1", 32'(tot_v1 - v0), 32'd0);
    chk("len1_pd", 32'(tx_pd_cdts), 32'd505);
    chk("len1_ph", 32'(tx_ph_cdts), 32'd61);

    // 4. CplD len 1024 then 5 back-to-back header-only messages
    snap();
    @(negedge clk);
    send(32'h4A00_0000, 1'b1, 1'b1);
    repeat (4) send(32'h3000_0000, 1'b1, 1'b1);
    chk("full_ready_low", 32'(st.tx_st_ready), 32'd0);
    send(32'h3000_0000, 1'b1, 1'b1);
    drain(20);
    chk("cpl_hdrs", 32'(tot_hdr - h0), 32'd6);
    chk("cpl_dpulses", 32'(tot_dp - d0), 32'd128);
    chk("cpl_val1", 32'(tot_v1 - v0), 32'd128);
    chk("cpl_cpld", 32'(tx_cpld_cdts), 32'd0);
    chk("cpl_fc", 32'(fc_violation), 32'd0);
    chk("cpl_ph", 32'(tx_ph_cdts), 32'd56);
    chk("cpl_ready", 32'(st.tx_st_ready), 32'd1);
    chk("cpl_tlp", tlp_count, 32'd10);

    // 5. return coincident with consumption, then saturation
    @(negedge clk);
    send(32'h3000_0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("net_hdr_pulse", 32'(hdr_p), 32'd1);
    ret_valid = 1'b1; ret_type = 2'b00; ret_hdr = 8'd1; ret_data = 12'd0;
    @(negedge clk);
    ret_valid = 1'b0; ret_hdr = 8'd0;
    @(negedge clk);
    chk("net_ph", 32'(tx_ph_cdts), 32'd56);
    ret_pulse(2'b00, 8'd255, 12'd0);
    chk("sat_ph_255", 32'(tx_ph_cdts), 32'd255);
    ret_pulse(2'b00, 8'd3, 12'd4000);
    chk("sat_ph_hold", 32'(tx_ph_cdts), 32'd255);
    chk("sat_pd", 32'(tx_pd_cdts), 32'd4095);
    chk("sat_tlp", tlp_count, 32'd11);

    // 6. reset again, drain the posted header pool, overdraw it
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_ph", 32'(tx_ph_cdts), 32'd64);
    chk("rst2_pd", 32'(tx_pd_cdts), 32'd512);
    chk("rst2_tlp", tlp_count, 32'd0);
    repeat (64) send(32'h3000_0000, 1'b1, 1'b1);
    drain(10);
    chk("empty_ph", 32'(tx_ph_cdts), 32'd0);
    chk("empty_fc", 32'(fc_violation), 32'd0);
    chk("empty_tlp", tlp_count, 32'd64);
    chk("sop_err_clear", 32'(sop_error), 32'd0);
    send(32'h0000_0000, 1'b0, 1'b1);
    drain(2);
    chk("sop_err_set", 32'(sop_error), 32'd1);
    send(32'h3000_0000, 1'b1, 1'b1);
    drain(6);
    chk("fcv_set", 32'(fc_violation), 32'd1);
    chk("fcv_ph", 32'(tx_ph_cdts), 32'd0);
    drain(3);
    chk("fcv_sticky", 32'(fc_violation), 32'd1);

    // asynchronous reset in the middle of a 128-pulse train
    send(32'h6000_0000, 1'b1, 1'b1);
    drain(10);
    chk("train_active", 32'(data_p), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_p), 32'd0);
    chk("arst_hdr", 32'(hdr_p), 32'd0);
    chk("arst_ph", 32'(tx_ph_cdts), 32'd64);
    chk("arst_pd", 32'(tx_pd_cdts), 32'd512);
    chk("arst_fc", 32'(fc_violation), 32'd0);
    chk("arst_sop_err", 32'(sop_error), 32'd0);
    chk("arst_tlp", tlp_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    drain(8);
    chk("arst_no_report", 32'(tot_dp - d0), 32'd0);
    chk("arst_pd_kept", 32'(tx_pd_cdts), 32'd512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
